// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma cipher sequencer.
// Holds the alphabet size, the lookup pass-select codes, the sequencer
// state encoding, the ASCII letter bounds and a rotor-position increment.
package enigma_pkg;

  localparam int unsigned ALPHA   = 26;
  localparam logic [4:0]  MAX_IDX = 5'd25;

  // Pass-select codes presented on lu_sel, in pass order.
  localparam logic [2:0] SEL_R1F = 3'd0;
  localparam logic [2:0] SEL_R2F = 3'd1;
  localparam logic [2:0] SEL_R3F = 3'd2;
  localparam logic [2:0] SEL_REF = 3'd3;
  localparam logic [2:0] SEL_R3I = 3'd4;
  localparam logic [2:0] SEL_R2I = 3'd5;
  localparam logic [2:0] SEL_R1I = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    OUT
  } state_t;

  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_UC_Z = 8'h5A;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;

  // Rotor position advance, 25 wraps to 0.
  function automatic logic [4:0] next_pos(input logic [4:0] p);
    return (p == MAX_IDX) ? 5'd0 : p + 5'd1;
  endfunction

endpackage

// File: rtl/enigma_mod26.sv
// Combinational (a + b) mod 26 or (a - b) mod 26 for operands in 0..25.
// Uses one conditional correction by 26 instead of a division.
//   a, b : operands (0..25)
//   sub  : 1 selects subtraction, 0 addition
//   y    : result (0..25)
module enigma_mod26
  import enigma_pkg::*;
(
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       sub,
  output logic [4:0] y
);

  logic [5:0] sum;
  logic [5:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    if (sub) begin
      // A borrow out of the 6-bit difference means the result went negative.
      y = diff[5] ? 5'(diff + 6'(ALPHA)) : diff[4:0];
    end else begin
      y = (sum >= 6'(ALPHA)) ? 5'(sum - 6'(ALPHA)) : sum[4:0];
    end
  end

endmodule

// File: rtl/enigma_sequencer.sv
// Time-multiplexed Enigma controller. Accepts one ASCII character at a time
// and steps a single shared substitution lookup unit through seven passes
// (rotor 1..3 forward, reflector, rotor 3..1 inverse). Owns rotor positions,
// offset arithmetic and per-rotor stepping cadence.
//   clk, reset          : clock, synchronous active-high reset
//   set, offset*, delay*: configuration load (IDLE only)
//   valid, ready, din   : character input handshake
//   dout, done, err     : one-cycle result pulse
//   lu_req/sel/idx      : lookup request, held until lu_ack
//   lu_ack, lu_data     : lookup response (ack may be same-cycle)
//   pos1..pos3          : current rotor positions
module enigma_sequencer
  import enigma_pkg::*;
#(
  parameter int unsigned DELAY_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic [4:0]         offset1,
  input  logic [4:0]         offset2,
  input  logic [4:0]         offset3,
  input  logic [DELAY_W-1:0] delay1,
  input  logic [DELAY_W-1:0] delay2,
  input  logic [DELAY_W-1:0] delay3,
  input  logic               valid,
  output logic               ready,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               done,
  output logic               err,
  output logic               lu_req,
  output logic [2:0]         lu_sel,
  output logic [4:0]         lu_idx,
  input  logic               lu_ack,
  input  logic [4:0]         lu_data,
  output logic [4:0]         pos1,
  output logic [4:0]         pos2,
  output logic [4:0]         pos3
);

  localparam logic [DELAY_W-1:0] CNT_ONE = DELAY_W'(1);

  state_t state, state_nx;

  logic [2:0]         pass;
  logic [4:0]         c;
  logic [7:0]         din_q;
  logic               letter;
  logic               ready_q;
  logic               err_q;
  logic [7:0]         dout_q;
  logic [4:0]         pos [3];
  logic [DELAY_W-1:0] cnt [3];
  logic [DELAY_W-1:0] dly [3];
  logic [4:0]         off [3];
  logic [DELAY_W-1:0] dly_in [3];

  logic       din_uc, din_lc, din_letter;
  logic [4:0] din_c;
  logic       accept, load;
  logic [4:0] pk, idx_sum, c_new;
  logic       lu_bad, last;

  assign off[0]    = offset1;
  assign off[1]    = offset2;
  assign off[2]    = offset3;
  assign dly_in[0] = delay1;
  assign dly_in[1] = delay2;
  assign dly_in[2] = delay3;

  always_comb begin
    din_uc     = (din >= ASCII_UC_A) && (din <= ASCII_UC_Z);
    din_lc     = (din >= ASCII_LC_A) && (din <= ASCII_LC_Z);
    din_letter = din_uc || din_lc;
    din_c      = 5'(din - (din_uc ? ASCII_UC_A : ASCII_LC_A));
    accept     = (state == IDLE) && valid && ready_q && !set;
    load       = (state == IDLE) && set;
    lu_bad     = lu_data > MAX_IDX;
    last       = pass == SEL_R1I;
  end

  // The reflector uses a zero rotor offset, so the same add/subtract path
  // yields lu_idx = c and c <= lu_data without a separate mux.
  always_comb begin
    unique case (pass)
      SEL_R1F, SEL_R1I: pk = pos[0];
      SEL_R2F, SEL_R2I: pk = pos[1];
      SEL_R3F, SEL_R3I: pk = pos[2];
      default:          pk = '0;
    endcase
  end

  enigma_mod26 u_pre_add  (.a(c),       .b(pk), .sub(1'b0), .y(idx_sum));
  enigma_mod26 u_post_sub (.a(lu_data), .b(pk), .sub(1'b1), .y(c_new));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = din_letter ? LOOKUP : OUT;
      LOOKUP:  if (lu_ack && (lu_bad || last)) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lu_req = state == LOOKUP;
    lu_sel = (state == LOOKUP) ? pass : '0;
    lu_idx = (state == LOOKUP) ? idx_sum : '0;
    done   = state == OUT;
    ready  = ready_q;
    dout   = dout_q;
    err    = err_q;
    pos1   = pos[0];
    pos2   = pos[1];
    pos3   = pos[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      pass    <= '0;
      c       <= '0;
      din_q   <= '0;
      letter  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      for (int unsigned k = 0; k < 3; k++) begin
        pos[k] <= '0;
        cnt[k] <= '0;
        dly[k] <= '0;
      end
    end else begin
      ready_q <= state_nx == IDLE;
      unique case (state)
        IDLE: begin
          if (load) begin
            for (int unsigned k = 0; k < 3; k++) begin
              pos[k] <= (off[k] > MAX_IDX) ? '0 : off[k];
              dly[k] <= dly_in[k];
              cnt[k] <= '0;
            end
          end else if (accept) begin
            pass   <= SEL_R1F;
            c      <= din_c;
            din_q  <= din;
            letter <= din_letter;
            if (!din_letter) begin
              dout_q <= din;
              err_q  <= 1'b0;
            end
          end
        end
        LOOKUP: begin
          if (lu_ack) begin
            if (lu_bad) begin
              dout_q <= din_q;
              err_q  <= 1'b1;
            end else begin
              c    <= c_new;
              pass <= pass + 3'd1;
              if (last) begin
                // Bit 5 of the original character distinguishes lower case.
                dout_q <= (din_q[5] ? ASCII_LC_A : ASCII_UC_A) + {3'b000, c_new};
                err_q  <= 1'b0;
              end
            end
          end
        end
        OUT: begin
          if (letter && !err_q) begin
            for (int unsigned k = 0; k < 3; k++) begin
              if (dly[k] != '0) begin
                if (cnt[k] + CNT_ONE == dly[k]) begin
                  cnt[k] <= '0;
                  pos[k] <= next_pos(pos[k]);
                end else begin
                  cnt[k] <= cnt[k] + CNT_ONE;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_sequencer.sv
// Self-checking bench for enigma_sequencer. Lookup unit modelled as identity
// rotors with reflector r -> 25-r, optional ack wait and data fault.
module tb_enigma_sequencer;

  localparam int unsigned DELAY_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               set;
  logic [4:0]         offset1, offset2, offset3;
  logic [DELAY_W-1:0] delay1, delay2, delay3;
  logic               valid;
  logic               ready;
  logic [7:0]         din;
  logic [7:0]         dout;
  logic               done;
  logic               err;
  logic               lu_req;
  logic [2:0]         lu_sel;
  logic [4:0]         lu_idx;
  logic               lu_ack;
  logic [4:0]         lu_data;
  logic [4:0]         pos1, pos2, pos3;

  always #5 clk = ~clk;

  enigma_sequencer #(.DELAY_W(DELAY_W)) dut (
    .clk(clk), .reset(reset), .set(set),
    .offset1(offset1), .offset2(offset2), .offset3(offset3),
    .delay1(delay1), .delay2(delay2), .delay3(delay3),
    .valid(valid), .ready(ready), .din(din),
    .dout(dout), .done(done), .err(err),
    .lu_req(lu_req), .lu_sel(lu_sel), .lu_idx(lu_idx),
    .lu_ack(lu_ack), .lu_data(lu_data),
    .pos1(pos1), .pos2(pos2), .pos3(pos3)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // ---------------- lookup unit model ----------------
  int unsigned ack_wait   = 0;
  int unsigned wait_cnt   = 0;
  logic        fault_en   = 1'b0;
  logic [2:0]  fault_pass = 3'd0;

  always @(posedge clk) begin
    if (reset || !lu_req || lu_ack) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    lu_ack = lu_req && (wait_cnt >= ack_wait);
    if (fault_en && lu_sel == fault_pass) lu_data = 5'd30;
    else if (lu_sel == 3'd3)              lu_data = 5'd25 - lu_idx;
    else                                  lu_data = lu_idx;
  end

  // ---------------- lookup monitor ----------------
  logic [2:0]  exp_sel_q [$];
  logic [4:0]  exp_idx_q [$];
  int unsigned extra_acks = 0;
  int unsigned req_cycles = 0;
  logic        pend = 1'b0;
  logic [2:0]  hold_sel;
  logic [4:0]  hold_idx;

  always @(negedge clk) begin
    if (lu_req) begin
      req_cycles++;
      if (pend) begin
        chk("sel_hold", 32'(lu_sel), 32'(hold_sel));
        chk("idx_hold", 32'(lu_idx), 32'(hold_idx));
      end
      if (lu_ack) begin
        pend = 1'b0;
        if (exp_idx_q.size() == 0) extra_acks++;
        else begin
          chk("lu_sel", 32'(lu_sel), 32'(exp_sel_q.pop_front()));
          chk("lu_idx", 32'(lu_idx), 32'(exp_idx_q.pop_front()));
        end
      end else begin
        pend     = 1'b1;
        hold_sel = lu_sel;
        hold_idx = lu_idx;
      end
    end else begin
      pend = 1'b0;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [7:0]  dout;
    logic        err;
    int unsigned lat;
    int unsigned nlu;
    logic        step;
  } exp_t;

  exp_t        sb [$];
  int unsigned mp [3];
  int unsigned mdly [3];
  int unsigned mcnt [3];

  task automatic model_char(input logic [7:0] ch, output exp_t e);
    int  c, p, idx, d;
    bit  uc, lc;
    uc = (ch >= 8'h41) && (ch <= 8'h5A);
    lc = (ch >= 8'h61) && (ch <= 8'h7A);
    e.step = 1'b0;
    if (!uc && !lc) begin
      e.dout = ch; e.err = 1'b0; e.lat = 1; e.nlu = 0;
      return;
    end
    c = uc ? int'(ch) - 65 : int'(ch) - 97;
    for (int s = 0; s < 7; s++) begin
      p   = (s == 0 || s == 6) ? int'(mp[0]) : (s == 1 || s == 5) ? int'(mp[1]) :
            (s == 2 || s == 4) ? int'(mp[2]) : 0;
      idx = (s == 3) ? c : (c + p) % 26;
      exp_sel_q.push_back(3'(s));
      exp_idx_q.push_back(5'(idx));
      if (fault_en && s == int'(fault_pass)) begin
        e.dout = ch; e.err = 1'b1; e.nlu = s + 1;
        e.lat  = (s + 1) * (ack_wait + 1) + 1;
        return;
      end
      d = (s == 3) ? 25 - idx : idx;
      c = (s == 3) ? d : (d - p + 26) % 26;
    end
    e.dout = 8'((uc ? 65 : 97) + c);
    e.err  = 1'b0;
    e.nlu  = 7;
    e.lat  = 7 * (ack_wait + 1) + 1;
    e.step = 1'b1;
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (mdly[k] != 0) begin
        mcnt[k]++;
        if (mcnt[k] == mdly[k]) begin
          mcnt[k] = 0;
          mp[k]   = (mp[k] + 1) % 26;
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mp[k] = 0; mdly[k] = 0; mcnt[k] = 0;
    end
    exp_sel_q.delete();
    exp_idx_q.delete();
    sb.delete();
  endtask

  task automatic chk_pos(input string tag);
    chk({tag, "_pos1"}, 32'(pos1), mp[0]);
    chk({tag, "_pos2"}, 32'(pos2), mp[1]);
    chk({tag, "_pos3"}, 32'(pos3), mp[2]);
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic cfg(input int unsigned o1, o2, o3, d1, d2, d3);
    @(negedge clk);
    set = 1'b1;
    offset1 = 5'(o1); offset2 = 5'(o2); offset3 = 5'(o3);
    delay1 = DELAY_W'(d1); delay2 = DELAY_W'(d2); delay3 = DELAY_W'(d3);
    @(negedge clk);
    set = 1'b0;
    mp[0] = (o1 > 25) ? 0 : o1;
    mp[1] = (o2 > 25) ? 0 : o2;
    mp[2] = (o3 > 25) ? 0 : o3;
    mdly[0] = d1; mdly[1] = d2; mdly[2] = d3;
    for (int k = 0; k < 3; k++) mcnt[k] = 0;
    chk_pos("cfg");
  endtask

  task automatic send(input logic [7:0] ch);
    exp_t        e;
    int unsigned n;
    int unsigned req0;
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before", 32'(ready), 32'd1);
    model_char(ch, e);
    sb.push_back(e);
    din   = ch;
    valid = 1'b1;
    req0  = req_cycles;
    @(negedge clk);
    valid = 1'b0;
    n = 1;
    while (!done && n < 200) begin @(negedge clk); n++; end
    e = sb.pop_front();
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", n, e.lat);
    chk("dout", 32'(dout), 32'(e.dout));
    chk("err", 32'(err), 32'(e.err));
    if (e.nlu == 0) chk("no_lookup", req_cycles - req0, 32'd0);
    @(negedge clk);
    chk("ready_after", 32'(ready), 32'd1);
    chk("done_pulse", 32'(done), 32'd0);
    if (e.step) model_step();
    chk_pos("step");
    chk("lu_left", exp_idx_q.size(), 32'd0);
    chk("lu_extra", extra_acks, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] edge_chars [6];
  logic       saw_done;
  exp_t       dummy;

  initial begin
    edge_chars = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h5A, 8'h7A};
    reset = 1'b1; set = 1'b0; valid = 1'b0; din = 8'h00;
    offset1 = '0; offset2 = '0; offset3 = '0;
    delay1 = '0; delay2 = '0; delay3 = '0;
    model_clear();

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_lu_req", 32'(lu_req), 32'd0);
    chk("rst_lu_sel", 32'(lu_sel), 32'd0);
    chk("rst_lu_idx", 32'(lu_idx), 32'd0);
    chk_pos("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_rise", 32'(ready), 32'd1);

    // Scenarios 1-2: identity rotors, rotor 1 steps every character
    cfg(0, 0, 0, 1, 0, 0);
    send(8'h41);
    chk("t1_pos1", 32'(pos1), 32'd1);
    send(8'h41);
    chk("t2_pos1", 32'(pos1), 32'd2);

    // Scenario 3: non-letters, lower case, letter-range edges
    send(8'h20);
    send(8'h61);
    foreach (edge_chars[i]) send(edge_chars[i]);

    // set together with valid: configuration wins, nothing accepted
    @(negedge clk);
    set = 1'b1; valid = 1'b1; din = 8'h41;
    offset1 = 5'd3; offset2 = 5'd4; offset3 = 5'd5;
    delay1 = '0; delay2 = '0; delay3 = '0;
    @(negedge clk);
    set = 1'b0; valid = 1'b0;
    mp[0] = 3; mp[1] = 4; mp[2] = 5;
    for (int k = 0; k < 3; k++) begin mdly[k] = 0; mcnt[k] = 0; end
    chk("setwin_lu_req", 32'(lu_req), 32'd0);
    chk("setwin_done", 32'(done), 32'd0);
    chk("setwin_ready", 32'(ready), 32'd1);
    chk_pos("setwin");
    send(8'h51);
    send(8'h6D);

    // Out-of-range offsets load as 0
    cfg(30, 26, 25, 0, 0, 0);
    send(8'h47);

    // Scenario 4: independent stepping cadence with wrap
    cfg(25, 0, 0, 1, 2, 0);
    send(8'h42);
    chk("t4a_pos1", 32'(pos1), 32'd0);
    chk("t4a_pos2", 32'(pos2), 32'd0);
    send(8'h43);
    chk("t4b_pos1", 32'(pos1), 32'd1);
    chk("t4b_pos2", 32'(pos2), 32'd1);

    // Scenario 5: every ack on the 4th request cycle
    ack_wait = 3;
    send(8'h45);
    ack_wait = 0;

    // Scenario 6a: out-of-range lookup data on pass 2
    fault_en = 1'b1; fault_pass = 3'd2;
    send(8'h4B);
    fault_en = 1'b0;

    // Scenario 6b: reset in the middle of a character
    cfg(0, 0, 0, 1, 0, 0);
    model_char(8'h41, dummy);
    saw_done = 1'b0;
    din = 8'h41; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    if (done) saw_done = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    chk("midrst_lu_req", 32'(lu_req), 32'd0);
    chk("midrst_ready_lo", 32'(ready), 32'd0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    if (done) saw_done = 1'b1;
    chk("midrst_ready_hi", 32'(ready), 32'd1);
    chk("midrst_no_done", 32'(saw_done), 32'd0);
    chk_pos("midrst");
    send(8'h41);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
